// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, timer-select and lamp encodings for the traffic-light system
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MG1  = 3'd0,
        ST_MG2  = 3'd1,
        ST_MY   = 3'd2,
        ST_WALK = 3'd3,
        ST_SG1  = 3'd4,
        ST_SG2  = 3'd5,
        ST_SY   = 3'd6
    } state_t;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    // led bits: main R/Y/G, side R/Y/G, walk
    localparam logic [6:0] LED_MG1  = 7'b0011000;
    localparam logic [6:0] LED_MG2  = 7'b0011000;
    localparam logic [6:0] LED_MY   = 7'b0101000;
    localparam logic [6:0] LED_WALK = 7'b1001001;
    localparam logic [6:0] LED_SG1  = 7'b1000010;
    localparam logic [6:0] LED_SG2  = 7'b1000010;
    localparam logic [6:0] LED_SY   = 7'b1000100;

endpackage

// File: rtl/traffic_led_decode.sv
// rtl/traffic_led_decode.sv - lamp pattern lookup for a controller state
module traffic_led_decode
    import traffic_pkg::*;
(
    input  state_t     state,
    output logic [6:0] led
);

    always_comb begin
        led = LED_MG1;
        case (state)
            ST_MG1:  led = LED_MG1;
            ST_MG2:  led = LED_MG2;
            ST_MY:   led = LED_MY;
            ST_WALK: led = LED_WALK;
            ST_SG1:  led = LED_SG1;
            ST_SG2:  led = LED_SG2;
            ST_SY:   led = LED_SY;
            default: led = LED_MG1;
        endcase
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - phase sequencer driving the lamp outputs and the external interval timer
module traffic_light_fsm
    import traffic_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       reset_sync,
    input  logic       prog_sync,
    input  logic       sensor_sync,
    input  logic       wr,
    input  logic       expired,
    output logic       wr_reset,
    output logic [1:0] interval,
    output logic       start_timer,
    output logic [6:0] led
);

    state_t     state;
    state_t     next_state;
    logic [1:0] next_interval;
    logic       next_start;
    logic       next_wr_reset;
    logic [6:0] next_led;

    // An expiry seen while start_timer is high belongs to the previous interval.
    always_comb begin
        next_state    = state;
        next_interval = interval;
        next_start    = 1'b0;
        next_wr_reset = 1'b0;
        if (reset_sync || prog_sync) begin
            next_state    = ST_MG1;
            next_interval = INT_BASE;
            next_start    = 1'b1;
        end else if (expired && !start_timer) begin
            next_start = 1'b1;
            case (state)
                ST_MG1: begin
                    next_state    = ST_MG2;
                    next_interval = sensor_sync ? INT_EXT : INT_BASE;
                end
                ST_MG2: begin
                    next_state    = ST_MY;
                    next_interval = INT_YEL;
                end
                ST_MY: begin
                    if (wr) begin
                        next_state    = ST_WALK;
                        next_interval = INT_EXT;
                        next_wr_reset = 1'b1;
                    end else begin
                        next_state    = ST_SG1;
                        next_interval = INT_BASE;
                    end
                end
                ST_WALK: begin
                    next_state    = ST_SG1;
                    next_interval = INT_BASE;
                end
                ST_SG1: begin
                    if (sensor_sync) begin
                        next_state    = ST_SG2;
                        next_interval = INT_EXT;
                    end else begin
                        next_state    = ST_SY;
                        next_interval = INT_YEL;
                    end
                end
                ST_SG2: begin
                    next_state    = ST_SY;
                    next_interval = INT_YEL;
                end
                default: begin
                    next_state    = ST_MG1;
                    next_interval = INT_BASE;
                end
            endcase
        end
    end

    traffic_led_decode u_led_decode (
        .state (next_state),
        .led   (next_led)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_MG1;
            interval    <= INT_BASE;
            start_timer <= 1'b1;
            wr_reset    <= 1'b0;
            led         <= LED_MG1;
        end else begin
            state       <= next_state;
            interval    <= next_interval;
            start_timer <= next_start;
            wr_reset    <= next_wr_reset;
            led         <= next_led;
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed and randomized self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       reset_sync;
    logic       prog_sync;
    logic       sensor_sync;
    logic       wr;
    logic       expired;
    logic       wr_reset;
    logic [1:0] interval;
    logic       start_timer;
    logic [6:0] led;

    traffic_light_fsm dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .reset_sync  (reset_sync),
        .prog_sync   (prog_sync),
        .sensor_sync (sensor_sync),
        .wr          (wr),
        .expired     (expired),
        .wr_reset    (wr_reset),
        .interval    (interval),
        .start_timer (start_timer),
        .led         (led)
    );

    always #5 clock = ~clock;

    localparam int P_MG1 = 0, P_MG2 = 1, P_MY = 2, P_WALK = 3, P_SG1 = 4, P_SG2 = 5, P_SY = 6;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_phase  = P_MG1;
    bit   m_start  = 1'b1;
    bit   m_wrr    = 1'b0;
    bit   m_ext    = 1'b0;

    function automatic logic [6:0] exp_led(input int p);
        case (p)
            P_MY:           return 7'b0101000;
            P_WALK:         return 7'b1001001;
            P_SG1, P_SG2:   return 7'b1000010;
            P_SY:           return 7'b1000100;
            default:        return 7'b0011000;
        endcase
    endfunction

    function automatic logic [1:0] exp_int(input int p, input bit ext);
        case (p)
            P_MG2:          return ext ? 2'b01 : 2'b00;
            P_MY, P_SY:     return 2'b10;
            P_WALK, P_SG2:  return 2'b01;
            default:        return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input bit rn, rs, ps, sen, w, e);
        if (!rn) begin
            m_phase = P_MG1; m_start = 1; m_wrr = 0;
        end else if (rs || ps) begin
            m_phase = P_MG1; m_start = 1; m_wrr = 0;
        end else if (e && !m_start) begin
            m_wrr = 0;
            case (m_phase)
                P_MG1:  begin m_ext = sen; m_phase = P_MG2; end
                P_MG2:  m_phase = P_MY;
                P_MY:   begin m_phase = w ? P_WALK : P_SG1; m_wrr = w; end
                P_WALK: m_phase = P_SG1;
                P_SG1:  m_phase = sen ? P_SG2 : P_SY;
                P_SG2:  m_phase = P_SY;
                default: m_phase = P_MG1;
            endcase
            m_start = 1;
        end else begin
            m_start = 0; m_wrr = 0;
        end
    endtask

    task automatic cycle(input bit rn, rs, ps, sen, w, e);
        reset_n = rn; reset_sync = rs; prog_sync = ps;
        sensor_sync = sen; wr = w; expired = e;
        @(posedge clock);
        model_edge(rn, rs, ps, sen, w, e);
        #1;
        check("led", led, exp_led(m_phase));
        check("interval", {5'b0, interval}, {5'b0, exp_int(m_phase, m_ext)});
        check("start_timer", {6'b0, start_timer}, {6'b0, m_start});
        check("wr_reset", {6'b0, wr_reset}, {6'b0, m_wrr});
    endtask

    // one idle cycle so start_timer drops, then a valid expiry
    task automatic advance(input bit sen, input bit w);
        cycle(1, 0, 0, sen, w, 0);
        cycle(1, 0, 0, sen, w, 1);
    endtask

    initial begin
        reset_n = 0; reset_sync = 0; prog_sync = 0;
        sensor_sync = 0; wr = 0; expired = 0;

        // reset held three cycles, then release
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        check("rst_led", led, 7'b0011000);
        check("rst_start", {6'b0, start_timer}, 7'd1);
        cycle(1, 0, 0, 0, 0, 0);
        check("rel_start", {6'b0, start_timer}, 7'd0);

        // full cycle, no sensor, no walk
        cycle(1, 0, 0, 0, 0, 1);
        advance(0, 0);
        check("my_led", led, 7'b0101000);
        check("my_int", {5'b0, interval}, 7'b0000010);
        advance(0, 0);
        check("sg1_led", led, 7'b1000010);
        advance(0, 0);
        check("sy_led", led, 7'b1000100);
        advance(0, 0);
        check("mg1_led", led, 7'b0011000);

        // sensor held high: MG2 extended, SG1 -> SG2 -> SY
        advance(1, 0);
        check("mg2_ext", {5'b0, interval}, 7'b0000001);
        advance(1, 0);
        advance(1, 0);
        advance(1, 0);
        check("sg2_int", {5'b0, interval}, 7'b0000001);
        check("sg2_led", led, 7'b1000010);
        advance(1, 0);
        check("sy2_led", led, 7'b1000100);
        advance(0, 0);

        // walk request at MY exit
        advance(0, 1);
        advance(0, 1);
        advance(0, 1);
        check("walk_led", led, 7'b1001001);
        check("walk_wrr", {6'b0, wr_reset}, 7'd1);
        cycle(1, 0, 0, 0, 0, 0);
        check("walk_wrr_drop", {6'b0, wr_reset}, 7'd0);
        cycle(1, 0, 0, 0, 0, 1);
        check("after_walk", led, 7'b1000010);

        // restart mid-SG1 together with an expiry
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 1, 1, 0, 1);
        check("restart_led", led, 7'b0011000);
        check("restart_start", {6'b0, start_timer}, 7'd1);

        // stale expiry while start_timer is high, then a real one
        cycle(1, 0, 0, 0, 0, 1);
        check("stale_led", led, 7'b0011000);
        cycle(1, 0, 0, 0, 0, 1);
        check("stale_then_adv", {6'b0, start_timer}, 7'd1);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 150) != 0, ($urandom % 50) == 0, ($urandom % 50) == 0,
                  1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Central controller of the traffic-light system: sequences main-street, side-street and pedestrian-walk lights. It requests each phase duration from the external programmable timer via `interval`/`start_timer` and advances on the timer's `expired` pulse. Inputs arrive already synchronised and debounced; outputs drive the timer, the walk-request register and the lamp drivers.

## Interface
- No parameters; the encodings below are fixed constants.
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low hardware reset.
- `reset_sync` in 1: synchronous active-high restart from the user button, already synchronised.
- `prog_sync` in 1: synchronous active-high pulse; a timer value was reprogrammed.
- `sensor_sync` in 1: side-street vehicle present, synchronous level.
- `wr` in 1: latched walk request, a level held by an external register.
- `expired` in 1: one-cycle pulse from the timer; the requested interval has elapsed.
- `wr_reset` out 1: one-cycle pulse that clears the external walk-request register.
- `interval` out 2: timer select. 00 = tBASE, 01 = tEXT, 10 = tYEL; 11 is never driven.
- `start_timer` out 1: one-cycle pulse; the timer loads the value selected by `interval`.
- `led` out 7: lamps, active-high. [6] main red, [5] main yellow, [4] main green, [3] side red, [2] side yellow, [1] side green, [0] walk.

## Operation
States and their outputs:
- MG1: interval tBASE; led 0011000.
- MG2: interval tEXT if `sensor_sync` was 1 at MG1 exit, else tBASE; led 0011000.
- MY: interval tYEL; led 0101000.
- WALK: interval tEXT; led 1001001.
- SG1: interval tBASE; led 1000010.
- SG2: interval tEXT; led 1000010.
- SY: interval tYEL; led 1000100.

Transitions, taken only on a *valid expiry*, meaning `expired`=1 while `start_timer`=0:
- MG1 -> MG2.
- MG2 -> MY.
- MY -> WALK if `wr`=1, else SG1.
- WALK -> SG1.
- SG1 -> SG2 if `sensor_sync`=1, else SY.
- SG2 -> SY.
- SY -> MG1.

Control rules:
- Priority, highest first: `reset_n` low, then `reset_sync`, then `prog_sync`, then a valid expiry.
- `reset_sync`=1 or `prog_sync`=1 forces MG1 on the next edge and restarts the timer, regardless of the current state.
- `expired` arriving in the same cycle as `start_timer` is stale and is ignored.
- `expired` while `reset_sync` or `prog_sync` is asserted is ignored.
- `wr` is sampled only at MY exit. `sensor_sync` is sampled only at MG1 exit and SG1 exit.
- In every other state, a `wr` assertion stays latched externally until the next MY exit.

## Timing
Registered outputs:
- All outputs are registered Moore outputs and are glitch-free.
- `led` and `interval` change on the same edge as the state.

Timer start:
- `start_timer` is 1 for exactly the first cycle of every state entry, including re-entry into MG1 by restart.
- `interval` is valid in that same cycle and stays stable for the whole state.

Walk-request clear:
- `wr_reset` is 1 for exactly the first cycle of WALK.
- Restart or reset during WALK does not produce a further `wr_reset`.

Reset values (while `reset_n`=0):
- state MG1, `led`=0011000, `interval`=00, `start_timer`=1, `wr_reset`=0.
- The first edge after release drops `start_timer`, so the timer has been loaded with tBASE.

Phase durations and latency:
- Main green lasts 2·tBASE with no sensor, tBASE+tEXT with sensor, plus a one-cycle restart gap per state.
- Latency from `expired` to the new `led`/`start_timer` is one clock.
- Consecutive `expired` pulses on back-to-back cycles: the second coincides with `start_timer` and is dropped.

## Structure
- Shared package `traffic_pkg` holds:
  - the state enum (3-bit);
  - the interval codes INT_BASE/INT_EXT/INT_YEL;
  - the seven `led` pattern constants.
- The same package is used by the timer and by display logic.
- Single module containing the state register, a combinational next-state block and an output register block.
- The `led` pattern lookup may live in a small sub-module `traffic_led_decode` (state in, 7-bit `led` out). No further hierarchy.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles -> `led`=0011000, `interval`=00, `start_timer`=1, `wr_reset`=0; after release, `start_timer`=0 on the next cycle.
- **Full cycle, no sensor, no walk:** pulse `expired` repeatedly -> `led` sequence 0011000, 0011000, 0101000, 1000010, 1000100, 0011000; `interval` sequence 00, 00, 10, 00, 10.
- **Sensor held 1:** MG2 `interval`=01; SG1 -> SG2 (`interval`=01, `led`=1000010) -> SY.
- **Walk:** `wr`=1 at MY expiry -> WALK with `led`=1001001, `interval`=01 and a one-cycle `wr_reset`=1; the next expiry enters SG1.
- **Restart mid-phase:** in SG1, assert `prog_sync` together with `expired` -> MG1, `start_timer`=1, `interval`=00, and no SG2/SY transition.
- **Stale expiry:** `expired`=1 in the cycle `start_timer`=1 -> state unchanged; a pulse one cycle later advances the state.
